// File: rtl/seq_cnt_monitor_if.sv
// seq_cnt_monitor_if: sample/control inputs and status outputs of the
// sequence-counter monitor, bundled so that producer and checker share one port.
// master: drives en/qin/clr and observes status.
// slave:  the monitor itself.
interface seq_cnt_monitor_if #(
    parameter int unsigned WRAP_W = 8,
    parameter int unsigned ERR_W  = 8
) ();
    logic              en;
    logic [3:0]        qin;
    logic              clr;
    logic              locked;
    logic              wrap_pulse;
    logic              err_pulse;
    logic [WRAP_W-1:0] wrap_cnt;
    logic [ERR_W-1:0]  err_cnt;

    modport master (
        output en, qin, clr,
        input  locked, wrap_pulse, err_pulse, wrap_cnt, err_cnt
    );

    modport slave (
        input  en, qin, clr,
        output locked, wrap_pulse, err_pulse, wrap_cnt, err_cnt
    );
endinterface

// File: rtl/seq_cnt_monitor.sv
// seq_cnt_monitor: downstream checker for the 4-bit sequence counter whose
// legal cycle is 0,1,3,7,9,11,13,14,0. It locks onto the stream after
// LOCK_LEN consecutive legal steps, then flags every illegal step, counting
// completed cycles (wrapping) and faults (saturating).
//
// Build option: define SEQ_MON_HOLD_FAULT_EN to make FAULT terminal. The
// monitor then ignores samples until clr (or rst) returns it to IDLE.
// Without it, FAULT resynchronises on the next valid sample like IDLE.
module seq_cnt_monitor #(
    parameter int unsigned LOCK_LEN = 2,
    parameter int unsigned WRAP_W   = 8,
    parameter int unsigned ERR_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    seq_cnt_monitor_if.slave   bus
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;
    localparam logic [1:0] ST_FAULT  = 2'd3;

    localparam logic [3:0]        LOCK_RUN = 4'(LOCK_LEN);
    localparam logic [3:0]        WRAP_SRC = 4'd14;
    localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);
    localparam logic [ERR_W-1:0]  ERR_ONE  = ERR_W'(1);
    localparam logic [ERR_W-1:0]  ERR_MAX  = {ERR_W{1'b1}};

    // Successor of a legal code. Non-members map to 15, which is never a
    // legal successor, so a comparison against it always fails.
    function automatic logic [3:0] succ(input logic [3:0] v);
        logic [3:0] r;
        case (v)
            4'd0:    r = 4'd1;
            4'd1:    r = 4'd3;
            4'd3:    r = 4'd7;
            4'd7:    r = 4'd9;
            4'd9:    r = 4'd11;
            4'd11:   r = 4'd13;
            4'd13:   r = 4'd14;
            4'd14:   r = 4'd0;
            default: r = 4'd15;
        endcase
        return r;
    endfunction

    // True for codes that appear in the legal cycle.
    function automatic logic is_member(input logic [3:0] v);
        logic r;
        case (v)
            4'd0, 4'd1, 4'd3, 4'd7, 4'd9, 4'd11, 4'd13, 4'd14: r = 1'b1;
            default:                                           r = 1'b0;
        endcase
        return r;
    endfunction

    logic [1:0]        state_q,      state_d;
    logic [3:0]        prev_q,       prev_d;
    logic [3:0]        run_q,        run_d;
    logic              locked_q,     locked_d;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic              err_pulse_q,  err_pulse_d;
    logic [WRAP_W-1:0] wrap_cnt_q,   wrap_cnt_d;
    logic [ERR_W-1:0]  err_cnt_q,    err_cnt_d;
    logic              wrap_ev_s;
    logic              err_ev_s;

    // Next-state logic: tracking FSM, last sample and legal-run length.
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        run_d     = run_q;
        wrap_ev_s = 1'b0;
        err_ev_s  = 1'b0;
        if (bus.en) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_member(bus.qin)) begin
                        prev_d  = bus.qin;
                        run_d   = 4'd0;
                        state_d = ST_SEARCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SEARCH: begin
                    if (bus.qin == succ(prev_q)) begin
                        prev_d = bus.qin;
                        run_d  = run_q + 4'd1;
                        if ((run_q + 4'd1) == LOCK_RUN) begin
                            state_d = ST_LOCKED;
                        end else begin
                            state_d = ST_SEARCH;
                        end
                    end else if (is_member(bus.qin)) begin
                        // Restart the run from this code
                        prev_d = bus.qin;
                        run_d  = 4'd0;
                    end else begin
                        run_d   = 4'd0;
                        state_d = ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (bus.qin == succ(prev_q)) begin
                        prev_d = bus.qin;
                        if (prev_q == WRAP_SRC) begin
                            wrap_ev_s = 1'b1;
                        end else begin
                            wrap_ev_s = 1'b0;
                        end
                    end else begin
                        // Includes a repeated value (stall while en=1)
                        err_ev_s = 1'b1;
                        state_d  = ST_FAULT;
                    end
                end
                ST_FAULT: begin
`ifdef SEQ_MON_HOLD_FAULT_EN
                    // Terminal: samples are ignored until clr or rst
                    state_d = ST_FAULT;
`else
                    // Resynchronise exactly as from IDLE
                    if (is_member(bus.qin)) begin
                        prev_d  = bus.qin;
                        run_d   = 4'd0;
                        state_d = ST_SEARCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
`endif
                end
                default: begin
                    state_d = ST_IDLE;
                    prev_d  = 4'd0;
                    run_d   = 4'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
`ifdef SEQ_MON_HOLD_FAULT_EN
        if (bus.clr && (state_q == ST_FAULT)) begin
            state_d = ST_IDLE;
            prev_d  = 4'd0;
            run_d   = 4'd0;
        end else begin
            state_d = state_d;
        end
`endif
    end

    // Output/counter next values; clr wins over a same-cycle increment.
    always_comb begin
        locked_d     = (state_d == ST_LOCKED);
        wrap_pulse_d = wrap_ev_s;
        err_pulse_d  = err_ev_s;
        if (bus.clr) begin
            wrap_cnt_d = '0;
        end else if (wrap_ev_s) begin
            wrap_cnt_d = wrap_cnt_q + WRAP_ONE;
        end else begin
            wrap_cnt_d = wrap_cnt_q;
        end
        if (bus.clr) begin
            err_cnt_d = '0;
        end else if (err_ev_s && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_ONE;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            prev_q       <= 4'd0;
            run_q        <= 4'd0;
            locked_q     <= 1'b0;
            wrap_pulse_q <= 1'b0;
            err_pulse_q  <= 1'b0;
            wrap_cnt_q   <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            run_q        <= run_d;
            locked_q     <= locked_d;
            wrap_pulse_q <= wrap_pulse_d;
            err_pulse_q  <= err_pulse_d;
            wrap_cnt_q   <= wrap_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bus.locked     = locked_q;
    assign bus.wrap_pulse = wrap_pulse_q;
    assign bus.err_pulse  = err_pulse_q;
    assign bus.wrap_cnt   = wrap_cnt_q;
    assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_seq_cnt_monitor.sv
// tb_seq_cnt_monitor: directed-vector scoreboard bench for seq_cnt_monitor.
// The DUT is built with LOCK_LEN=2, WRAP_W=2, ERR_W=2 so that wrap-around
// and saturation are reached quickly.
module tb_seq_cnt_monitor;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    typedef struct {
        logic [6:0] exp;   // {locked, wrap_pulse, err_pulse, wrap_cnt[1:0], err_cnt[1:0]}
        string      name;
    } exp_t;

    exp_t sb_q[$];

    seq_cnt_monitor_if #(.WRAP_W(2), .ERR_W(2)) bus ();

    seq_cnt_monitor #(.LOCK_LEN(2), .WRAP_W(2), .ERR_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] act_vec();
        return {bus.locked, bus.wrap_pulse, bus.err_pulse, bus.wrap_cnt, bus.err_cnt};
    endfunction

    task automatic report(input string nm, input logic [6:0] a, input logic [6:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got L=%0b W=%0b E=%0b wc=%0d ec=%0d, expected L=%0b W=%0b E=%0b wc=%0d ec=%0d",
                     nm, a[6], a[5], a[4], a[3:2], a[1:0], e[6], e[5], e[4], e[3:2], e[1:0]);
        end
    endtask

    // Monitor: after every rising edge compare the DUT against the next expectation.
    always @(posedge clk) begin
        #1;
        if (!rst && (sb_q.size() > 0)) begin
            exp_t e;
            e = sb_q.pop_front();
            report(e.name, act_vec(), e.exp);
        end
    end

    // Drive one sample and queue the outputs expected after the next edge.
    task automatic step(input string nm, input logic e, input logic [3:0] q, input logic c,
                        input logic l, input logic w, input logic er,
                        input logic [1:0] wc, input logic [1:0] ec);
        exp_t x;
        @(negedge clk);
        bus.en  = e;
        bus.qin = q;
        bus.clr = c;
        x.exp   = {l, w, er, wc, ec};
        x.name  = nm;
        sb_q.push_back(x);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst     = 1'b1;
        bus.en  = 1'b0;
        bus.qin = 4'd0;
        bus.clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        report("reset_state", act_vec(), 7'b0);
        @(negedge clk);
        rst = 1'b0;

        // Lock onto a full cycle and see the wrap
        step("t1_0",  1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        step("t1_1",  1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        step("t1_3",  1'b1, 4'd3,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        step("t1_7",  1'b1, 4'd7,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        step("t1_9",  1'b1, 4'd9,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        step("t1_11", 1'b1, 4'd11, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        step("t1_13", 1'b1, 4'd13, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        step("t1_14", 1'b1, 4'd14, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        step("t1_wrap", 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 2'd0);

        // en=0 with garbage: nothing moves, pulse drops
        for (int i = 0; i < 3; i++) begin
            step("t3_hold", 1'b0, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0);
        end
        step("t3_1", 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0);
        step("t3_3", 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0);
        step("t3_7", 1'b1, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0);

        // Asynchronous reset between edges while LOCKED
        @(negedge clk);
        rst = 1'b1;
        #1;
        report("t5_async_rst", act_vec(), 7'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step("t5_0", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        step("t5_1", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        step("t5_3", 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        step("t5_7", 1'b1, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);

`ifdef SEQ_MON_HOLD_FAULT_EN
        // Terminal fault: legal stream is ignored until clr
        step("t6_err", 1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1);
        step("t6_9",   1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1);
        step("t6_11",  1'b1, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1);
        step("t6_13",  1'b1, 4'd13, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1);
        step("t6_14",  1'b1, 4'd14, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1);
        step("t6_0",   1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1);
        step("t6_clr", 1'b1, 4'd1,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        step("t6_r0",  1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        step("t6_r1",  1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        step("t6_r3",  1'b1, 4'd3,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
`else
        // Illegal step, resync and relock
        step("t2_err", 1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1);
        step("t2_9",   1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1);
        step("t2_11",  1'b1, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1);
        step("t2_13",  1'b1, 4'd13, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1);
        step("t2_14",  1'b1, 4'd14, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1);
        // Stall with en=1 is a fault
        step("t4_stall", 1'b1, 4'd14, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2);
        step("t4_r13",   1'b1, 4'd13, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2);
        step("t4_r14",   1'b1, 4'd14, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2);
        step("t4_r0",    1'b1, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd2);
        step("t4_nonmem",1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd3);
        step("t4_s0",    1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3);
        step("t4_s1",    1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3);
        step("t4_s3",    1'b1, 4'd3,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd3);
        step("t4_sat1",  1'b1, 4'd4,  1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd3);
        step("t4_u7",    1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3);
        step("t4_u9",    1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3);
        step("t4_u11",   1'b1, 4'd11, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd3);
        step("t4_sat2",  1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd3);
        // Non-member while in FAULT drops back to IDLE
        step("t4_f15",   1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3);
        step("t4_v9",    1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3);
        step("t4_v11",   1'b1, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3);
        step("t4_v13",   1'b1, 4'd13, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd3);
        step("t4_v14",   1'b1, 4'd14, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd3);
        // clr on the wrap cycle: counters 0, pulse still fires
        step("t4_clrwrap", 1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
        // Four more cycles: wrap_cnt 1,2,3 then rolls to 0
        for (int k = 1; k <= 4; k++) begin
            logic [1:0] before_c;
            logic [1:0] after_c;
            before_c = 2'(k - 1);
            after_c  = 2'(k);
            step("t4_mid",  1'b1, 4'd1,  1'b0, 1'b1, 1'b0, 1'b0, before_c, 2'd0);
            step("t4_mid",  1'b1, 4'd3,  1'b0, 1'b1, 1'b0, 1'b0, before_c, 2'd0);
            step("t4_mid",  1'b1, 4'd7,  1'b0, 1'b1, 1'b0, 1'b0, before_c, 2'd0);
            step("t4_mid",  1'b1, 4'd9,  1'b0, 1'b1, 1'b0, 1'b0, before_c, 2'd0);
            step("t4_mid",  1'b1, 4'd11, 1'b0, 1'b1, 1'b0, 1'b0, before_c, 2'd0);
            step("t4_mid",  1'b1, 4'd13, 1'b0, 1'b1, 1'b0, 1'b0, before_c, 2'd0);
            step("t4_mid",  1'b1, 4'd14, 1'b0, 1'b1, 1'b0, 1'b0, before_c, 2'd0);
            step("t4_roll", 1'b1, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, after_c,  2'd0);
        end
`endif
        step("idle_end", 1'b0, 4'd0, 1'b0, 1'b1 ^ 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        // the last sample above differs per build; drop it and recheck below
        void'(sb_q.pop_back());
        bus.en = 1'b0;

        // Bounded drain of the scoreboard
        for (int i = 0; i < 20; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
        end
        #2;
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
